des_core: RTL and testbench



---
 rtl/des_defines.sv | 138 +++++++++++++
 rtl/des_round_f.sv | 24 ++
 rtl/des_core.sv | 122 ++++++++++++
 tb/tb_des_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/des_defines.sv
// Shared DES constants: permutation tables, key shift schedule, S-boxes,
// FSM encoding and the permutation helpers used by the core and the f-function.
package des_defines;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } des_state_e;

    localparam int unsigned NUM_ROUNDS = 16;
    localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS - 1);

    // Tables use FIPS 46-3 numbering: entry n names input bit n, bit 1 being the MSB.
    localparam logic [6:0] IP_T [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [6:0] FP_T [64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    localparam logic [6:0] E_T [48] = '{
        7'd32, 7'd1,  7'd2,  7'd3,  7'd4,  7'd5,
        7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd9,
        7'd8,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13,
        7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17,
        7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21,
        7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25,
        7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29,
        7'd28, 7'd29, 7'd30, 7'd31, 7'd32, 7'd1
    };

    localparam logic [6:0] P_T [32] = '{
        7'd16, 7'd7,  7'd20, 7'd21, 7'd29, 7'd12, 7'd28, 7'd17,
        7'd1,  7'd15, 7'd23, 7'd26, 7'd5,  7'd18, 7'd31, 7'd10,
        7'd2,  7'd8,  7'd24, 7'd14, 7'd32, 7'd27, 7'd3,  7'd9,
        7'd19, 7'd13, 7'd30, 7'd6,  7'd22, 7'd11, 7'd4,  7'd25
    };

    localparam logic [6:0] PC1_T [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [6:0] PC2_T [48] = '{
        7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,
        7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
        7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,
        7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
        7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55,
        7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
        7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53,
        7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
    };

    localparam logic [1:0] SHIFT_T [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // One 64-bit word per S-box row; column 0 is the most significant nibble.
    localparam logic [63:0] SBOX_T [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - int'(IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - int'(FP_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47 - i] = x[32 - int'(E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31 - i] = x[32 - int'(P_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55 - i] = x[64 - int'(PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47 - i] = x[56 - int'(PC2_T[i])];
        return y;
    endfunction

    // Row comes from the outer two bits of the 6-bit group, column from the inner four.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
        logic [63:0] row_word;
        logic [3:0]  col;
        row_word = SBOX_T[box][{six[5], six[0]}];
        col      = six[4:1];
        return row_word[{~col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/des_round_f.sv
// DES f-function: expansion, subkey mix, eight S-boxes and the P permutation.
// Purely combinational; the core registers its result through L/R.
module des_round_f
    import des_defines::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] mix_s;
    logic [31:0] sbox_out_s;

    // Expand, mix with the round key and substitute six bits at a time.
    always_comb begin
        mix_s      = e_perm(r_i) ^ k_i;
        sbox_out_s = 32'd0;
        for (int b = 0; b < 8; b++) begin
            sbox_out_s[31 - 4*b -: 4] = sbox_lookup(3'(b), mix_s[47 - 6*b -: 6]);
        end
        f_o = p_perm(sbox_out_s);
    end

endmodule

// File: rtl/des_core.sv
// Iterative DES engine: one Feistel round per clock, 16-cycle latency from the
// accepted start strobe. Decryption walks the key schedule backwards by rotating right.
module des_core
    import des_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        des_encipher_en,
    input  logic        des_decipher_en,
    input  logic [63:0] des_data,
    input  logic [63:0] des_key_in,
    output logic [63:0] desc_result,
    output logic        desc_ready
);

    des_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        decrypt_q, decrypt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [1:0]  rot_amt_s;
    logic [27:0] c_rot_s, d_rot_s;
    logic [47:0] subkey_s;
    logic [31:0] f_s;

    // Per-round C/D rotation; decryption skips the rotation before its first round.
    always_comb begin
        rot_amt_s = (decrypt_q && (cnt_q == 4'd0)) ? 2'd0 : SHIFT_T[cnt_q];
        case ({decrypt_q, rot_amt_s})
            3'b0_01: begin c_rot_s = {c_q[26:0], c_q[27]};    d_rot_s = {d_q[26:0], d_q[27]};    end
            3'b0_10: begin c_rot_s = {c_q[25:0], c_q[27:26]}; d_rot_s = {d_q[25:0], d_q[27:26]}; end
            3'b1_01: begin c_rot_s = {c_q[0], c_q[27:1]};     d_rot_s = {d_q[0], d_q[27:1]};     end
            3'b1_10: begin c_rot_s = {c_q[1:0], c_q[27:2]};   d_rot_s = {d_q[1:0], d_q[27:2]};   end
            default: begin c_rot_s = c_q;                     d_rot_s = d_q;                     end
        endcase
        subkey_s = pc2_perm({c_rot_s, d_rot_s});
    end

    des_round_f u_round_f (
        .r_i (r_q),
        .k_i (subkey_s),
        .f_o (f_s)
    );

    // FSM next state, operand capture and round datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decrypt_d = decrypt_q;
        l_d       = l_q;
        r_d       = r_q;
        c_d       = c_q;
        d_d       = d_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (des_encipher_en || des_decipher_en) begin
                    decrypt_d  = ~des_encipher_en;
                    {l_d, r_d} = ip_perm(des_data);
                    {c_d, d_d} = pc1_perm(des_key_in);
                    cnt_d      = 4'd0;
                    ready_d    = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                l_d = r_q;
                r_d = l_q ^ f_s;
                c_d = c_rot_s;
                d_d = d_rot_s;
                if (cnt_q == LAST_ROUND) begin
                    // Halves swap back before the final permutation.
                    result_d = fp_perm({l_q ^ f_s, r_q});
                    ready_d  = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            decrypt_q <= 1'b0;
            l_q       <= 32'd0;
            r_q       <= 32'd0;
            c_q       <= 28'd0;
            d_q       <= 28'd0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decrypt_q <= decrypt_d;
            l_q       <= l_d;
            r_q       <= r_d;
            c_q       <= c_d;
            d_q       <= d_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign desc_result = result_q;
    assign desc_ready  = ready_q;

endmodule

// File: tb/tb_des_core.sv
// Self-checking bench for des_core: known-answer vectors plus random blocks
// checked against a bit-array DES model that precomputes all sixteen subkeys.
module tb_des_core;

    logic        clk;
    logic        rst_n;
    logic        des_encipher_en;
    logic        des_decipher_en;
    logic [63:0] des_data;
    logic [63:0] des_key_in;
    logic [63:0] desc_result;
    logic        desc_ready;

    int          checks_cnt;
    int          fail_cnt;
    logic [63:0] last_exp;

    localparam logic [63:0] KEY_A    = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B    = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PAR_MASK = 64'h0101010101010101;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SCHED_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX_T [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    des_core dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .des_encipher_en (des_encipher_en),
        .des_decipher_en (des_decipher_en),
        .des_data        (des_data),
        .des_key_in      (des_key_in),
        .desc_result     (desc_result),
        .desc_ready      (desc_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference DES on arrays indexed by FIPS bit number; decryption uses the subkeys in reverse.
    function automatic logic [63:0] ref_des(input logic [63:0] din, input logic [63:0] key, input bit decrypt);
        bit blk [1:64];
        bit kb [1:64];
        bit cd [1:56];
        bit sk [1:16][1:48];
        bit l [1:32];
        bit r [1:32];
        bit er [1:48];
        bit so [1:32];
        bit fo [1:32];
        bit pre [1:64];
        bit t;
        int rnd, row, col, v;
        logic [63:0] dout;
        for (int n = 1; n <= 64; n++) begin blk[n] = din[64-n]; kb[n] = key[64-n]; end
        for (int j = 1; j <= 56; j++) cd[j] = kb[PC1_T[j-1]];
        for (int i = 1; i <= 16; i++) begin
            for (int s = 0; s < SCHED_T[i-1]; s++) begin
                t = cd[1];  for (int j = 1; j < 28; j++) cd[j] = cd[j+1];  cd[28] = t;
                t = cd[29]; for (int j = 29; j < 56; j++) cd[j] = cd[j+1]; cd[56] = t;
            end
            for (int j = 1; j <= 48; j++) sk[i][j] = cd[PC2_T[j-1]];
        end
        for (int j = 1; j <= 32; j++) begin l[j] = blk[IP_T[j-1]]; r[j] = blk[IP_T[j+31]]; end
        for (int i = 1; i <= 16; i++) begin
            rnd = decrypt ? 17 - i : i;
            for (int j = 1; j <= 48; j++) er[j] = r[E_T[j-1]] ^ sk[rnd][j];
            for (int s = 0; s < 8; s++) begin
                row = 2*int'(er[6*s+1]) + int'(er[6*s+6]);
                col = 8*int'(er[6*s+2]) + 4*int'(er[6*s+3]) + 2*int'(er[6*s+4]) + int'(er[6*s+5]);
                v = SBOX_T[s][row*16 + col];
                for (int b = 0; b < 4; b++) so[4*s+1+b] = v[3-b];
            end
            for (int j = 1; j <= 32; j++) fo[j] = so[P_T[j-1]];
            for (int j = 1; j <= 32; j++) begin t = l[j] ^ fo[j]; l[j] = r[j]; r[j] = t; end
        end
        for (int j = 1; j <= 32; j++) begin pre[j] = r[j]; pre[j+32] = l[j]; end
        dout = 64'd0;
        for (int j = 1; j <= 64; j++) dout[64 - IP_T[j-1]] = pre[j];
        return dout;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, scramble the inputs afterwards, and time the completion.
    task automatic run_op(input string tag, input logic [63:0] data, input logic [63:0] key,
                          input bit enc, input bit dec, input bit mid_pulse, output logic [63:0] res);
        int n;
        des_data        = data;
        des_key_in      = key;
        des_encipher_en = enc;
        des_decipher_en = dec;
        tick();
        des_encipher_en = 1'b0;
        des_decipher_en = 1'b0;
        des_data        = {$urandom, $urandom};
        des_key_in      = {$urandom, $urandom};
        check_eq($sformatf("%s_rdy_clr", tag), {63'd0, desc_ready}, 64'd0);
        check_eq($sformatf("%s_hold", tag), desc_result, last_exp);
        n = 0;
        while (n < 40 && !desc_ready) begin
            if (mid_pulse && n == 7) begin
                des_encipher_en = 1'b1;
                des_decipher_en = 1'b1;
            end
            tick();
            n++;
            des_encipher_en = 1'b0;
            des_decipher_en = 1'b0;
        end
        check_eq($sformatf("%s_lat", tag), 64'(n), 64'd16);
        res = desc_result;
    endtask

    task automatic op_check(input string tag, input logic [63:0] data, input logic [63:0] key,
                            input bit enc, input bit dec, input bit mid_pulse, input logic [63:0] exp);
        logic [63:0] res;
        run_op(tag, data, key, enc, dec, mid_pulse, res);
        check_eq($sformatf("%s_res", tag), res, exp);
        last_exp = exp;
    endtask

    initial begin
        logic [63:0] d, k, c;
        int seen;
        bit dir;
        checks_cnt      = 0;
        fail_cnt        = 0;
        last_exp        = 64'd0;
        rst_n           = 1'b0;
        des_encipher_en = 1'b1;
        des_decipher_en = 1'b1;
        des_data        = 64'h0123456789ABCDEF;
        des_key_in      = KEY_A;
        repeat (5) tick();
        check_eq("rst_result", desc_result, 64'd0);
        check_eq("rst_ready", {63'd0, desc_ready}, 64'd0);
        rst_n           = 1'b1;
        des_encipher_en = 1'b0;
        des_decipher_en = 1'b0;
        seen = 0;
        repeat (20) begin tick(); if (desc_ready) seen++; end
        check_eq("rst_strobe_ignored", 64'(seen), 64'd0);

        op_check("enc_a", 64'h0123456789ABCDEF, KEY_A, 1'b1, 1'b0, 1'b0, 64'h85E813540F0AB405);
        op_check("dec_a", 64'h85E813540F0AB405, KEY_A, 1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF);
        repeat (5) tick();
        check_eq("idle_hold", desc_result, last_exp);
        op_check("enc_k0133", 64'h0123456789ABCDEF, 64'h0133457799BBCDFF, 1'b1, 1'b0, 1'b0,
                 ref_des(64'h0123456789ABCDEF, 64'h0133457799BBCDFF, 1'b0));
        op_check("enc_b", 64'h8787878787878787, KEY_B, 1'b1, 1'b0, 1'b0, 64'h0000000000000000);
        op_check("dec_b", 64'h0000000000000000, KEY_B, 1'b0, 1'b1, 1'b0, 64'h8787878787878787);
        op_check("par_all", 64'h8787878787878787, KEY_B ^ PAR_MASK, 1'b1, 1'b0, 1'b0, 64'h0);
        op_check("par_rnd", 64'h8787878787878787, KEY_B ^ ({$urandom, $urandom} & PAR_MASK), 1'b1, 1'b0, 1'b0, 64'h0);
        op_check("mid_strobe", 64'h0123456789ABCDEF, KEY_A, 1'b1, 1'b0, 1'b1, 64'h85E813540F0AB405);
        op_check("both_strobes", 64'h0123456789ABCDEF, KEY_A, 1'b1, 1'b1, 1'b0, 64'h85E813540F0AB405);

        d = {$urandom, $urandom};
        k = {$urandom, $urandom};
        for (int i = 0; i < 9; i++) begin
            c = ref_des(d, k, 1'b0);
            op_check($sformatf("b2b_enc%0d", i), d, k, 1'b1, 1'b0, 1'b0, c);
            op_check($sformatf("b2b_dec%0d", i), c, k, 1'b0, 1'b1, 1'b0, d);
            d = d >> 1;
            k = k >> 1;
        end
        for (int i = 0; i < 6; i++) begin
            d   = {$urandom, $urandom};
            k   = {$urandom, $urandom};
            dir = 1'($urandom_range(0, 1));
            op_check($sformatf("rnd%0d", i), d, k, ~dir, dir, 1'b0, ref_des(d, k, dir));
        end

        des_data        = 64'h0123456789ABCDEF;
        des_key_in      = KEY_A;
        des_encipher_en = 1'b1;
        tick();
        des_encipher_en = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check_eq("abort_result", desc_result, 64'd0);
        check_eq("abort_ready", {63'd0, desc_ready}, 64'd0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (24) begin tick(); if (desc_ready) seen++; end
        check_eq("abort_no_ready", 64'(seen), 64'd0);
        last_exp = 64'd0;
        op_check("post_abort", 64'h0123456789ABCDEF, KEY_A, 1'b1, 1'b0, 1'b0, 64'h85E813540F0AB405);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
